// File: rtl/ice_bus_responder.sv
// ICE bus slave endpoint: captures master frames addressed to ADDR into an RX FIFO
// and streams a locally built TX frame onto the shared, tri-stated slave bus.
module ice_bus_responder #(
  parameter logic [7:0]  ADDR       = 8'h00,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ma_data,
  input  logic [7:0] ma_addr,
  input  logic       ma_data_valid,
  input  logic       ma_frame_valid,
  input  logic       sl_overflow,
  input  logic       sl_arb_grant,
  output logic       sl_arb_request,
  output logic [7:0] sl_data,
  output logic       sl_data_latch,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_frame_done,
  output logic       rx_frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_latch,
  input  logic       tx_commit,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;

  typedef enum logic [1:0] {R_IDLE, R_CAPTURE, R_SKIP} rx_state_t;
  typedef enum logic [1:0] {T_FILL, T_REQ, T_SEND, T_DONE} tx_state_t;

  rx_state_t  rx_state_q, rx_state_d;
  logic [7:0] rx_mem_q [DEPTH];
  ptr_t       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       ovf_q, ovf_d;
  logic       done_q, done_d, err_q, err_d;
  logic       rx_empty, rx_full, rx_pop, rx_push_req, rx_push;

  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[DEPTH_LOG2] != rx_rd_q[DEPTH_LOG2]) &&
                    (rx_wr_q[DEPTH_LOG2-1:0] == rx_rd_q[DEPTH_LOG2-1:0]);
  assign rx_pop   = rx_ack && !rx_empty;
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_push_req = 1'b0;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (ma_frame_valid) begin
          if (ma_addr == ADDR) begin
            rx_state_d  = R_CAPTURE;
            rx_push_req = ma_data_valid;
          end else begin
            rx_state_d = R_SKIP;
          end
        end
      end
      R_CAPTURE: begin
        if (ma_frame_valid) begin
          rx_push_req = ma_data_valid;
        end else begin
          rx_state_d = R_IDLE;
          if (ovf_q) begin
            err_d = 1'b1;
            ovf_d = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      R_SKIP:  if (!ma_frame_valid) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
    if (rx_push_req && !rx_push) ovf_d = 1'b1;
  end

  // Registered head: next head is the incoming byte when the FIFO drains to empty this cycle.
  always_comb begin
    rx_rd_d   = rx_rd_q + ptr_t'(rx_pop);
    rx_wr_d   = rx_wr_q + ptr_t'(rx_push);
    rx_data_d = rx_data_q;
    if (rx_rd_d == rx_wr_q) begin
      if (rx_push) rx_data_d = ma_data;
    end else begin
      rx_data_d = rx_mem_q[rx_rd_d[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= R_IDLE;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_data_q  <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_data_q  <= rx_data_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q[DEPTH_LOG2-1:0]] <= ma_data;
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = !rx_empty;
  assign rx_frame_done = done_q;
  assign rx_frame_err  = err_q;

  tx_state_t  tx_state_q, tx_state_d;
  logic [7:0] tx_mem_q [DEPTH];
  ptr_t       tx_wr_q, tx_rd_q;
  logic       tx_empty, tx_full, tx_idle, tx_push, tx_pop, tx_last;
  logic [7:0] sl_data_int;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[DEPTH_LOG2] != tx_rd_q[DEPTH_LOG2]) &&
                    (tx_wr_q[DEPTH_LOG2-1:0] == tx_rd_q[DEPTH_LOG2-1:0]);
  assign tx_idle  = (tx_state_q == T_FILL) || (tx_state_q == T_DONE);
  assign tx_push  = tx_idle && tx_latch && !tx_full;
  assign tx_pop   = (tx_state_q == T_SEND) && sl_arb_grant && !sl_overflow && !tx_empty;
  assign tx_last  = tx_pop && ((tx_rd_q + ptr_t'(1)) == tx_wr_q);

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      T_FILL, T_DONE: begin
        // A byte latched alongside the commit counts towards a non-empty frame.
        if (tx_commit && (!tx_empty || tx_latch)) tx_state_d = T_REQ;
        else                                      tx_state_d = T_FILL;
      end
      T_REQ:   if (sl_arb_grant) tx_state_d = T_SEND;
      T_SEND:  if (tx_last) tx_state_d = T_DONE;
      default: tx_state_d = T_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= T_FILL;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_wr_q    <= tx_wr_q + ptr_t'(tx_push);
      tx_rd_q    <= tx_rd_q + ptr_t'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[DEPTH_LOG2-1:0]] <= tx_data;
  end

  assign sl_arb_request = (tx_state_q == T_REQ) || (tx_state_q == T_SEND);
  assign tx_busy        = sl_arb_request;
  assign tx_done        = (tx_state_q == T_DONE);
  assign sl_data_int    = tx_pop ? tx_mem_q[tx_rd_q[DEPTH_LOG2-1:0]] : '0;
  assign sl_data        = sl_arb_grant ? sl_data_int : 'z;
  assign sl_data_latch  = sl_arb_grant ? tx_pop : 1'bz;

endmodule

// File: doc/ice_bus_responder.md
# ice_bus_responder

Reusable slave-side endpoint for the ICE internal bus, and the counterpart of the bus controller's master/arbiter logic. Ingress: it watches the master-driven bus, captures every frame whose message type matches `ADDR`, and queues the payload bytes for local logic. Egress: it accepts a locally built response frame, requests the shared slave bus, and streams the bytes to the controller under arbitration grant with overflow back-pressure. Instantiated once per bus client, with the client's grant/request lane connected.

## Interface
- `ADDR` = 8'h00: message type this responder accepts.
- `DEPTH_LOG2` = 4: log2 depth of each of the RX and TX FIFOs (16 bytes each).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ma_data`  in  8  master byte; valid when `ma_data_valid`.
- `ma_addr`  in  8  message type; stable while `ma_frame_valid`.
- `ma_data_valid`  in  1  one-cycle strobe per master byte.
- `ma_frame_valid`  in  1  high for the whole master frame.
- `sl_overflow`  in  1  controller output buffer full; stall egress.
- `sl_arb_grant`  in  1  this client owns the slave bus.
- `sl_arb_request`  out  1  request for the slave bus.
- `sl_data`  out  8  egress byte; high-Z unless granted.
- `sl_data_latch`  out  1  egress byte strobe; high-Z unless granted.
- `rx_data`  out  8  head of the RX FIFO.
- `rx_valid`  out  1  RX FIFO is non-empty.
- `rx_ack`  in  1  pop the RX head.
- `rx_frame_done`  out  1  one-cycle pulse when a matched frame ends cleanly.
- `rx_frame_err`  out  1  one-cycle pulse when a matched frame ends after RX overflow.
- `tx_data`  in  8  byte to append to the TX frame.
- `tx_latch`  in  1  append `tx_data`.
- `tx_commit`  in  1  close the TX frame and start sending.
- `tx_busy`  out  1  a frame is committed and not yet fully sent.
- `tx_done`  out  1  one-cycle pulse after the last byte is sent.

## Operation
- **RX FSM states:** R_IDLE, R_CAPTURE, R_SKIP.
  - R_IDLE, on a cycle where `ma_frame_valid` is high: go to R_CAPTURE if `ma_addr==ADDR`, otherwise to R_SKIP.
  - In R_CAPTURE, every `ma_data_valid` pushes `ma_data` into the RX FIFO. This includes a strobe in the same cycle that `ma_frame_valid` first rises.
  - A push while the FIFO is full is dropped and sets the sticky `ovf` flag. If `rx_ack` pops in the same cycle, the FIFO is not full and the push is accepted.
  - On the first cycle with `ma_frame_valid` low, return to R_IDLE. Pulse `rx_frame_err` if `ovf` is set (then clear it), otherwise pulse `rx_frame_done`.
  - A strobe in the last cycle of `ma_frame_valid` is captured.
  - R_SKIP ignores all bytes and returns to R_IDLE when `ma_frame_valid` falls.
  - Bytes already queued stay readable regardless of `ovf`.
- **TX FSM states:** T_FILL, T_REQ, T_SEND, T_DONE.
  - T_FILL: `tx_latch` pushes into the TX FIFO; pushes while full are dropped.
  - `tx_commit` with a non-empty FIFO goes to T_REQ and sets `tx_busy`. `tx_commit` with an empty FIFO is ignored.
  - If `tx_latch` and `tx_commit` coincide, the byte is included in the frame.
  - T_REQ: assert `sl_arb_request`; go to T_SEND on the first cycle `sl_arb_grant` is seen high.
  - T_SEND: each cycle with grant high, `sl_overflow` low and FIFO non-empty, drive the head on `sl_data`, assert `sl_data_latch`, and pop.
  - Grant low or `sl_overflow` high stalls: `sl_data_latch` is 0 and nothing is popped.
  - After the last pop, go to T_DONE.
  - T_DONE: drop `sl_arb_request`, clear `tx_busy`, pulse `tx_done`, return to T_FILL.
  - `tx_latch` and `tx_commit` are ignored while `tx_busy` is set.
- **Tri-state:** `sl_data` and `sl_data_latch` are driven only while `sl_arb_grant` is high, and are 'z' otherwise. While granted but idle, they drive 8'h00 and 0.
- **FIFO pointers:** `DEPTH_LOG2`+1 bits wide. Wrap-around is natural binary overflow. Full when the MSBs differ and the remaining bits are equal.

## Timing
- Reset values:
  - `sl_arb_request`, `rx_valid`, `rx_frame_done`, `rx_frame_err`, `tx_busy`, `tx_done` = 0.
  - `rx_data` = 8'h00; `sl_data` and `sl_data_latch` = 'z.
  - Both FIFOs empty; both FSMs in their idle states (R_IDLE, T_FILL); `ovf` cleared.
- RX latency: `rx_valid` and `rx_data` update one cycle after the accepted `ma_data_valid`. `rx_data` comes from a registered head, not a combinational path.
- `rx_frame_done` / `rx_frame_err` assert exactly one cycle after `ma_frame_valid` falls.
- `sl_arb_request` rises the cycle after `tx_commit`.
- The first `sl_data_latch` occurs the cycle after grant is first sampled high.
- After that, one byte per unstalled cycle.
- `sl_arb_request` falls, and `tx_done` pulses, the cycle after the final `sl_data_latch`.
- Reset mid-frame or mid-send flushes both FIFOs and drops the request the next cycle. There is no partial `tx_done` or `rx_frame_*` pulse.

## Test plan
- Matched frame (`ADDR`=8'h42, `ma_addr`=8'h42, bytes 01,02,03) -> `rx_data` sequence 01,02,03; `rx_frame_done` pulses once; `rx_frame_err` stays 0.
- Mismatched frame (`ma_addr`=8'h43, 5 bytes) -> `rx_valid` stays 0; no pulses.
- RX overflow: 20 bytes 00..13 with no `rx_ack` -> bytes 00..0F are readable; `rx_frame_err` pulses; the next clean frame produces `rx_frame_done`.
- TX send:
  - Latch AA,BB,CC, then commit.
  - Grant 3 cycles later -> `sl_data_latch` high for 3 consecutive cycles carrying AA,BB,CC.
  - The next cycle: request low and `tx_done` pulse.
- TX stall: assert `sl_overflow` for 2 cycles after byte AA -> no latch during the stall; BB resumes the cycle `sl_overflow` drops; the byte order is intact.
- Reset asserted in T_SEND after 1 byte -> next cycle request 0, `tx_busy` 0, `sl_data` 'z; a fresh commit sends only the new bytes.
